// File: rtl/program_counter_pkg.sv
// Shared constants, operation encoding and sizing helper for the program counter.
package program_counter_pkg;

  localparam int          DEFAULT_WIDTH        = 16;
  localparam int          DEFAULT_DEPTH        = 8;
  localparam int unsigned DEFAULT_RESET_VECTOR = 32'd0;

  // Operation selected for the current cycle after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_RET  = 3'd2,
    OP_CALL = 3'd3,
    OP_LOAD = 3'd4,
    OP_INC  = 3'd5
  } pc_op_e;

  // Ceiling log2, used to size the depth counter and the stack pointer.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/program_counter_pc_incr.sv
// PC incrementer: half-adder ripple chain with the carry-in tied high.
module pc_incr
  import program_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  logic carry_s;

  // Ripple through one half adder per bit; the final carry-out is dropped so
  // the all-ones value wraps to zero.
  always_comb begin
    carry_s = 1'b1;
    sum     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = a[i] ^ carry_s;
      carry_s = a[i] & carry_s;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Program counter with a circular return-address stack for call/ret.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int          WIDTH        = DEFAULT_WIDTH,
  parameter int          DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        inc,
  input  logic                        load,
  input  logic                        call,
  input  logic                        ret,
  input  logic [WIDTH-1:0]            target,
  output logic [WIDTH-1:0]            pc,
  output logic [clog2(DEPTH+1)-1:0]   stk_depth,
  output logic                        stk_full,
  output logic                        stk_empty,
  output logic                        stk_err
);

  localparam int                 DEPTH_W = clog2(DEPTH + 1);
  localparam int                 PTR_W   = clog2(DEPTH);
  localparam logic [WIDTH-1:0]   RV      = WIDTH'(RESET_VECTOR);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   stack_q [DEPTH];
  logic [WIDTH-1:0]   pc_plus1_s;
  logic [PTR_W-1:0]   top_idx_s;
  logic               push_s;
  pc_op_e             op_s;

  // Single shared incrementer feeds both the inc path and the call push value.
  pc_incr #(.WIDTH(WIDTH)) u_incr (
    .a   (pc_q),
    .sum (pc_plus1_s)
  );

  // ptr_q is the next write slot, so the top entry sits one below it.
  assign top_idx_s = ptr_q - PTR_ONE;

  // Resolve the per-cycle request into the single operation that takes effect.
  always_comb begin
    op_s = OP_HOLD;
    if (clr) begin
      op_s = OP_CLR;
    end else if (!en) begin
      op_s = OP_HOLD;
    end else if (ret) begin
      op_s = OP_RET;
    end else if (call) begin
      op_s = OP_CALL;
    end else if (load) begin
      op_s = OP_LOAD;
    end else if (inc) begin
      op_s = OP_INC;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next-state computation for pc, stack pointer, depth and the sticky error.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    push_s  = 1'b0;
    case (op_s)
      OP_CLR: begin
        pc_d    = RV;
        depth_d = '0;
        ptr_d   = '0;
        err_d   = 1'b0;
      end
      OP_RET: begin
        if (depth_q == '0) begin
          err_d = 1'b1;
        end else begin
          pc_d    = stack_q[top_idx_s];
          depth_d = depth_q - DEPTH_ONE;
          ptr_d   = top_idx_s;
        end
      end
      OP_CALL: begin
        // When full, the write slot holds the oldest entry, so it is overwritten.
        push_s = 1'b1;
        pc_d   = target;
        ptr_d  = ptr_q + PTR_ONE;
        if (depth_q == DEPTH_MAX) begin
          err_d = 1'b1;
        end else begin
          depth_d = depth_q + DEPTH_ONE;
        end
      end
      OP_LOAD: pc_d = target;
      OP_INC:  pc_d = pc_plus1_s;
      default: pc_d = pc_q;
    endcase
  end

  // Control state: asynchronously reset, updated on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RV;
      depth_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; a zero depth hides stale contents.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[ptr_q] <= pc_plus1_s;
    end
  end

  assign pc        = pc_q;
  assign stk_depth = depth_q;
  assign stk_err   = err_q;
  assign stk_full  = (depth_q == DEPTH_MAX);
  assign stk_empty = (depth_q == '0);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus random ops
// compared against a queue-based reference model.
module tb_program_counter;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n, clr, en, inc, load, call, ret;
  logic [15:0] target;
  logic [15:0] pc;
  logic [3:0]  stk_depth;
  logic        stk_full, stk_empty, stk_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [15:0] m_pc;
  logic        m_err;
  logic [15:0] m_stk [$];

  always #5 clk = ~clk;

  program_counter #(.WIDTH(16), .DEPTH(8), .RESET_VECTOR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .inc       (inc),
    .load      (load),
    .call      (call),
    .ret       (ret),
    .target    (target),
    .pc        (pc),
    .stk_depth (stk_depth),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"},    {16'd0, pc},        {16'd0, m_pc});
    chk({tag, ".depth"}, {28'd0, stk_depth}, m_stk.size());
    chk({tag, ".full"},  {31'd0, stk_full},  {31'd0, (m_stk.size() == D)});
    chk({tag, ".empty"}, {31'd0, stk_empty}, {31'd0, (m_stk.size() == 0)});
    chk({tag, ".err"},   {31'd0, stk_err},   {31'd0, m_err});
  endtask

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // Architectural behaviour: a bounded LIFO of return addresses.
  task automatic model_step(input logic c, e, i, l, ca, r, input logic [15:0] t);
    logic [15:0] nx;
    logic [15:0] dropped;
    nx = m_pc + 16'd1;
    if (c) begin
      model_reset();
    end else if (!e) begin
      m_pc = m_pc;
    end else if (r) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (ca) begin
      if (m_stk.size() == D) begin
        dropped = m_stk.pop_front();
        m_err   = 1'b1;
      end
      m_stk.push_back(nx);
      m_pc = t;
    end else if (l) begin
      m_pc = t;
    end else if (i) begin
      m_pc = nx;
    end
  endtask

  // One clock of stimulus, called at a falling edge; checks at the next one.
  task automatic cyc(input logic c, e, i, l, ca, r, input logic [15:0] t, input string tag);
    clr = c; en = e; inc = i; load = l; call = ca; ret = r; target = t;
    model_step(c, e, i, l, ca, r, t);
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; inc = 1'b0; load = 1'b0;
    call = 1'b0; ret = 1'b0; target = 16'h0000;
    model_reset();
    #12;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then inc, and wrap from all-ones.
    cyc(0, 1, 1, 0, 0, 0, 16'h0000, "inc1");
    cyc(0, 1, 1, 0, 0, 0, 16'h0000, "inc2");
    cyc(0, 1, 1, 0, 0, 0, 16'h0000, "inc3");
    chk("inc3_pc_const", {16'd0, pc}, 32'h0000_0003);
    cyc(0, 1, 0, 1, 0, 0, 16'hFFFF, "load_ffff");
    cyc(0, 1, 1, 0, 0, 0, 16'h0000, "wrap");
    chk("wrap_pc_const", {16'd0, pc}, 32'h0000_0000);
    chk("wrap_err_const", {31'd0, stk_err}, 32'd0);

    // Nested calls and returns.
    cyc(0, 1, 0, 1, 0, 0, 16'h0010, "nest_load");
    cyc(0, 1, 0, 0, 1, 0, 16'h0100, "nest_call1");
    chk("nest_call1_pc", {16'd0, pc}, 32'h0000_0100);
    cyc(0, 1, 0, 0, 1, 0, 16'h0200, "nest_call2");
    chk("nest_call2_depth", {28'd0, stk_depth}, 32'd2);
    cyc(0, 1, 0, 0, 0, 1, 16'h0000, "nest_ret1");
    chk("nest_ret1_pc", {16'd0, pc}, 32'h0000_0101);
    cyc(0, 1, 0, 0, 0, 1, 16'h0000, "nest_ret2");
    chk("nest_ret2_pc", {16'd0, pc}, 32'h0000_0011);
    chk("nest_ret2_depth", {28'd0, stk_depth}, 32'd0);

    // Overflow: nine calls, then eight returns.
    cyc(1, 0, 0, 0, 0, 0, 16'h0000, "ovf_clr");
    for (int k = 0; k < 9; k++) begin
      cyc(0, 1, 0, 0, 1, 0, 16'h1000 + 16'(k * 16), "ovf_call");
    end
    chk("ovf_full", {31'd0, stk_full}, 32'd1);
    chk("ovf_err", {31'd0, stk_err}, 32'd1);
    chk("ovf_depth", {28'd0, stk_depth}, 32'd8);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, 0, 0, 1, 16'h0000, "ovf_ret");
      if (k == 0) chk("ovf_first_ret", {16'd0, pc}, 32'h0000_1071);
    end
    chk("ovf_last_ret", {16'd0, pc}, 32'h0000_1001);
    chk("ovf_empty", {31'd0, stk_empty}, 32'd1);

    // Underflow with sticky error until clr.
    cyc(1, 1, 0, 0, 0, 0, 16'h0000, "unf_clr");
    cyc(0, 1, 0, 1, 0, 0, 16'h0042, "unf_load");
    cyc(0, 1, 0, 0, 0, 1, 16'h0000, "unf_ret");
    chk("unf_pc", {16'd0, pc}, 32'h0000_0042);
    chk("unf_err", {31'd0, stk_err}, 32'd1);
    cyc(0, 1, 1, 0, 0, 0, 16'h0000, "unf_hold_err");
    chk("unf_err_sticky", {31'd0, stk_err}, 32'd1);
    cyc(1, 1, 0, 0, 0, 0, 16'h0000, "unf_clear");
    chk("unf_err_cleared", {31'd0, stk_err}, 32'd0);

    // Priority and stall.
    cyc(0, 0, 1, 1, 0, 0, 16'h5555, "stall");
    chk("stall_pc", {16'd0, pc}, 32'h0000_0000);
    cyc(0, 1, 0, 0, 1, 0, 16'h0300, "prio_call");
    cyc(0, 1, 0, 0, 1, 1, 16'h0400, "prio_call_ret");
    chk("prio_ret_pc", {16'd0, pc}, 32'h0000_0001);
    chk("prio_ret_depth", {28'd0, stk_depth}, 32'd0);
    cyc(0, 1, 0, 1, 0, 0, 16'h0ABC, "prio_load");
    cyc(1, 0, 0, 0, 0, 0, 16'h0000, "clr_no_en");
    chk("clr_no_en_pc", {16'd0, pc}, 32'h0000_0000);

    // Async reset in the middle of a call.
    cyc(0, 1, 0, 0, 1, 0, 16'h0600, "arst_pre");
    clr = 1'b0; en = 1'b1; inc = 1'b0; load = 1'b0; call = 1'b1; ret = 1'b0;
    target = 16'h0777;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", {16'd0, pc}, 32'h0000_0000);
    chk("arst_depth", {28'd0, stk_depth}, 32'd0);
    chk("arst_err", {31'd0, stk_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(0, 1, 1, 0, 0, 0, 16'h0000, "arst_after");

    // Random operations against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic c, e, i, l, ca, r;
      c  = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 99) < 30);
      ca = ($urandom_range(0, 99) < 40);
      l  = ($urandom_range(0, 99) < 20);
      i  = ($urandom_range(0, 99) < 60);
      cyc(c, e, i, l, ca, r, 16'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
